apb_req_arbiter: RTL and testbench



---
 rtl/apb_req_arbiter_if.sv | 55 +++++
 rtl/apb_req_arbiter.sv | 164 ++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_req_arbiter_if.sv
// rtl/apb_req_arbiter_if.sv - requester and bridge command signals for apb_req_arbiter
interface apb_req_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req0_valid;
    logic                  req0_write;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic                  req0_ready;
    logic                  req0_done;
    logic [DATA_WIDTH-1:0] req0_rdata;
    logic                  req0_err;

    logic                  req1_valid;
    logic                  req1_write;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic                  req1_ready;
    logic                  req1_done;
    logic [DATA_WIDTH-1:0] req1_rdata;
    logic                  req1_err;

    logic                  transfer;
    logic                  READ_WRITE;
    logic [ADDR_WIDTH-1:0] apb_writeAddr;
    logic [ADDR_WIDTH-1:0] apb_readAddr;
    logic [DATA_WIDTH-1:0] apb_writeData;
    logic [DATA_WIDTH-1:0] apb_readData_out;
    logic                  PENABLE;
    logic                  PREADY;
    logic                  busy;

    // Arbiter side: serves the requesters and drives the bridge command port
    modport master (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        output req0_ready, req0_done, req0_rdata, req0_err,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req1_ready, req1_done, req1_rdata, req1_err,
        output transfer, READ_WRITE, apb_writeAddr, apb_readAddr, apb_writeData,
        input  apb_readData_out, PENABLE, PREADY,
        output busy
    );

    // Environment side: requesters plus the APB bridge
    modport slave (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        input  req0_ready, req0_done, req0_rdata, req0_err,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req1_ready, req1_done, req1_rdata, req1_err,
        input  transfer, READ_WRITE, apb_writeAddr, apb_readAddr, apb_writeData,
        output apb_readData_out, PENABLE, PREADY,
        input  busy
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - two-requester arbiter/sequencer for the APB bridge; optional APB_REQ_TIMEOUT_EN
module apb_req_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int FIXED_PRIO     = 0,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    apb_req_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t                state;
    logic                  rr_ptr;
    logic                  owner;
    logic                  setup_phase;
    logic                  transfer_q;
    logic                  rw_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [ADDR_WIDTH-1:0] raddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  busy_q;
    logic                  done0_q;
    logic                  done1_q;
    logic [DATA_WIDTH-1:0] rdata0_q;
    logic [DATA_WIDTH-1:0] rdata1_q;

    logic                  tie_to_req0;
    logic                  grant0;
    logic                  grant1;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  xfer_done;

`ifdef APB_REQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          err0_q;
    logic          err1_q;

    assign tmo_hit      = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign bus.req0_err = err0_q;
    assign bus.req1_err = err1_q;
`else
    assign bus.req0_err = 1'b0;
    assign bus.req1_err = 1'b0;
`endif

    // A single valid always wins; on a tie the parameter or the rr pointer decides
    assign tie_to_req0 = (FIXED_PRIO != 0) || !rr_ptr;
    assign grant0      = bus.req0_valid && (!bus.req1_valid || tie_to_req0);
    assign grant1      = bus.req1_valid && !grant0;

    assign sel_write = grant1 ? bus.req1_write : bus.req0_write;
    assign sel_addr  = grant1 ? bus.req1_addr  : bus.req0_addr;
    assign sel_wdata = grant1 ? bus.req1_wdata : bus.req0_wdata;

    // The setup cycle of an APB access can never complete it
    assign xfer_done = bus.PENABLE && bus.PREADY && !setup_phase;

    assign bus.req0_ready    = (state == IDLE) && !PRESET && grant0;
    assign bus.req1_ready    = (state == IDLE) && !PRESET && grant1;
    assign bus.req0_done     = done0_q;
    assign bus.req1_done     = done1_q;
    assign bus.req0_rdata    = rdata0_q;
    assign bus.req1_rdata    = rdata1_q;
    assign bus.transfer      = transfer_q;
    assign bus.READ_WRITE    = rw_q;
    assign bus.apb_writeAddr = waddr_q;
    assign bus.apb_readAddr  = raddr_q;
    assign bus.apb_writeData = wdata_q;
    assign bus.busy          = busy_q;

    // Arbitration FSM: grant in IDLE, hold the access in XFER, pulse done in DONE
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            owner       <= 1'b0;
            setup_phase <= 1'b0;
            transfer_q  <= 1'b0;
            rw_q        <= 1'b0;
            waddr_q     <= '0;
            raddr_q     <= '0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
`ifdef APB_REQ_TIMEOUT_EN
            tmo_cnt     <= '0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
`endif
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
`ifdef APB_REQ_TIMEOUT_EN
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        owner       <= grant1;
                        rw_q        <= sel_write;
                        if (sel_write) begin
                            waddr_q <= sel_addr;
                            wdata_q <= sel_wdata;
                        end else begin
                            raddr_q <= sel_addr;
                        end
                        transfer_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        setup_phase <= 1'b1;
`ifdef APB_REQ_TIMEOUT_EN
                        tmo_cnt     <= '0;
`endif
                        state       <= XFER;
                    end
                end
                XFER: begin
                    setup_phase <= 1'b0;
                    if (xfer_done) begin
                        transfer_q <= 1'b0;
                        state      <= DONE;
                        if (owner) begin
                            done1_q <= 1'b1;
                            if (!rw_q) rdata1_q <= bus.apb_readData_out;
                        end else begin
                            done0_q <= 1'b1;
                            if (!rw_q) rdata0_q <= bus.apb_readData_out;
                        end
                    end
`ifdef APB_REQ_TIMEOUT_EN
                    else if (tmo_hit) begin
                        transfer_q <= 1'b0;
                        state      <= DONE;
                        if (owner) begin
                            done1_q <= 1'b1;
                            err1_q  <= 1'b1;
                        end else begin
                            done0_q <= 1'b1;
                            err0_q  <= 1'b1;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    rr_ptr <= ~owner;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - scoreboard bench for apb_req_arbiter (instance 0 round-robin, instance 1 fixed priority)
module tb_apb_req_arbiter;
    logic PCLK = 1'b0;
    logic PRESET;
    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;

    typedef struct { int id; logic [31:0] rdata; logic err; } cexp_t;
    typedef struct { logic wr; logic [31:0] addr; logic [31:0] wdata; } bexp_t;
    cexp_t cq [2][$];
    bexp_t bq [2][$];

    logic [1:0]  v [2];
    logic [1:0]  w [2];
    logic [31:0] a [2][2];
    logic [31:0] d [2][2];
    logic [1:0]  rdy [2];
    logic [1:0]  dn [2];
    logic [1:0]  er [2];
    logic [31:0] rd [2][2];
    logic        tr [2];
    logic        rw [2];
    logic        bsy [2];
    logic [31:0] wa [2];
    logic [31:0] ra [2];
    logic [31:0] wd [2];
    logic [31:0] brd [2];
    logic        pen [2];
    logic        prdy [2];
    logic        stall [2];

    for (genvar g = 0; g < 2; g++) begin : u
        apb_req_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
        assign bus.req0_valid = v[g][0];
        assign bus.req0_write = w[g][0];
        assign bus.req0_addr  = a[g][0];
        assign bus.req0_wdata = d[g][0];
        assign bus.req1_valid = v[g][1];
        assign bus.req1_write = w[g][1];
        assign bus.req1_addr  = a[g][1];
        assign bus.req1_wdata = d[g][1];
        assign rdy[g]   = {bus.req1_ready, bus.req0_ready};
        assign dn[g]    = {bus.req1_done, bus.req0_done};
        assign er[g]    = {bus.req1_err, bus.req0_err};
        assign rd[g][0] = bus.req0_rdata;
        assign rd[g][1] = bus.req1_rdata;
        assign tr[g]    = bus.transfer;
        assign rw[g]    = bus.READ_WRITE;
        assign wa[g]    = bus.apb_writeAddr;
        assign ra[g]    = bus.apb_readAddr;
        assign wd[g]    = bus.apb_writeData;
        assign bsy[g]   = bus.busy;
        assign bus.apb_readData_out = brd[g];
        assign bus.PENABLE          = pen[g];
        assign bus.PREADY           = prdy[g];

        apb_req_arbiter #(
            .ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIO(g), .TIMEOUT_CYCLES(16)
        ) dut (
            .PCLK(PCLK),
            .PRESET(PRESET),
            .bus(bus)
        );
    end

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endfunction

    // Bridge model: PENABLE from the 2nd transfer cycle, PREADY with it unless stalled
    int xcnt [2] = '{0, 0};
    always @(negedge PCLK) begin
        for (int g = 0; g < 2; g++) begin
            if (tr[g] === 1'b1) xcnt[g]++;
            else xcnt[g] = 0;
            pen[g]  = (tr[g] === 1'b1) && (xcnt[g] >= 2);
            prdy[g] = pen[g] && !stall[g];
            brd[g]  = (ra[g] == 32'h10) ? 32'hDEAD_BEEF : {ra[g][15:0], 16'hC0DE};
        end
    end

    // Monitor: pops expected bridge commands on transfer rise and completions on done
    logic  tr_prev [2] = '{1'b0, 1'b0};
    logic  have_b [2]  = '{1'b0, 1'b0};
    logic [1:0] dn_prev [2] = '{2'b00, 2'b00};
    int    tlen [2] = '{0, 0};
    int    last_tlen [2] = '{0, 0};
    bexp_t cur_b [2];
    always @(negedge PCLK) begin
        if (PRESET === 1'b0) begin
            for (int g = 0; g < 2; g++) begin
                if (dn[g] != 2'b00) begin
                    chk($sformatf("done_onehot%0d", g), 32'($countones(dn[g])), 32'd1);
                    chk($sformatf("done_width%0d", g), 32'(dn_prev[g]), 32'd0);
                    if (cq[g].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done%0d: got done=%b expected none", g, dn[g]);
                    end else begin
                        cexp_t e;
                        e = cq[g].pop_front();
                        chk($sformatf("done_id%0d", g), 32'(dn[g][1]), 32'(e.id));
                        chk($sformatf("rdata%0d", g), rd[g][e.id], e.rdata);
                        chk($sformatf("err%0d", g), 32'(er[g][e.id]), 32'(e.err));
                    end
                end
                dn_prev[g] = dn[g];
                if (tr[g]) begin
                    if (!tr_prev[g]) begin
                        tlen[g] = 0;
                        have_b[g] = (bq[g].size() != 0);
                        if (have_b[g]) cur_b[g] = bq[g].pop_front();
                        else begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_transfer%0d: got transfer=1 expected 0", g);
                        end
                    end
                    tlen[g]++;
                    if (have_b[g]) begin
                        chk($sformatf("rw%0d", g), 32'(rw[g]), 32'(cur_b[g].wr));
                        if (cur_b[g].wr) begin
                            chk($sformatf("waddr%0d", g), wa[g], cur_b[g].addr);
                            chk($sformatf("wdata%0d", g), wd[g], cur_b[g].wdata);
                        end else begin
                            chk($sformatf("raddr%0d", g), ra[g], cur_b[g].addr);
                        end
                    end
                end else if (tr_prev[g]) begin
                    last_tlen[g] = tlen[g];
                    chk($sformatf("xfer_len_min%0d", g), 32'(tlen[g] >= 2), 32'd1);
                end
                tr_prev[g] = tr[g];
            end
        end else begin
            for (int g = 0; g < 2; g++) begin
                tr_prev[g] = 1'b0;
                dn_prev[g] = 2'b00;
            end
        end
    end

    logic        cw [2][4];
    logic [31:0] ca [2][4];
    logic [31:0] cd [2][4];
    int          cn [2];

    task automatic set_cmd(input int id, input int k, input logic wr, input logic [31:0] ad, input logic [31:0] wdat);
        cw[id][k] = wr;
        ca[id][k] = ad;
        cd[id][k] = wdat;
    endtask

    task automatic push_b(input int g, input logic wr, input logic [31:0] ad, input logic [31:0] wdat);
        bexp_t b;
        b.wr = wr; b.addr = ad; b.wdata = wdat;
        bq[g].push_back(b);
    endtask

    task automatic push_c(input int g, input int id, input logic [31:0] rdat, input logic e);
        cexp_t c;
        c.id = id; c.rdata = rdat; c.err = e;
        cq[g].push_back(c);
    endtask

    task automatic load(input int g, input int id, input int k);
        v[g][id] = 1'b1;
        w[g][id] = cw[id][k];
        a[g][id] = ca[id][k];
        d[g][id] = cd[id][k];
    endtask

    // Drives both requesters of instance g through their command lists, valid held continuously
    task automatic run(input int g);
        int   idx [2];
        int   cyc;
        logic [1:0] acc;
        idx[0] = 0;
        idx[1] = 0;
        cyc = 0;
        @(negedge PCLK);
        for (int id = 0; id < 2; id++) if (cn[id] > 0) load(g, id, 0);
        while ((idx[0] < cn[0] || idx[1] < cn[1]) && cyc < 500) begin
            #1;
            acc = rdy[g];
            cyc++;
            if (acc != 2'b00) begin
                @(posedge PCLK);
                #1;
                for (int id = 0; id < 2; id++) begin
                    if (acc[id]) begin
                        idx[id]++;
                        if (idx[id] < cn[id]) load(g, id, idx[id]);
                        else v[g][id] = 1'b0;
                    end
                end
            end
            @(negedge PCLK);
        end
        while ((cq[g].size() != 0 || bsy[g]) && cyc < 500) begin
            @(negedge PCLK);
            cyc++;
        end
        chk($sformatf("run_complete%0d", g), 32'(cyc < 500), 32'd1);
    endtask

    initial begin
        int cyc;
        PRESET = 1'b1;
        for (int g = 0; g < 2; g++) begin
            v[g] = 2'b00; w[g] = 2'b00; stall[g] = 1'b0;
            for (int i = 0; i < 2; i++) begin a[g][i] = '0; d[g][i] = '0; end
        end
        repeat (2) @(posedge PCLK);
        #1;
        v[0] = 2'b11;
        @(negedge PCLK);
        chk("ready_in_reset", 32'(rdy[0]), 32'd0);
        v[0] = 2'b00;
        @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(negedge PCLK);
        for (int g = 0; g < 2; g++) begin
            chk("rst_transfer", 32'(tr[g]), 32'd0);
            chk("rst_busy", 32'(bsy[g]), 32'd0);
            chk("rst_rw", 32'(rw[g]), 32'd0);
            chk("rst_done", 32'(dn[g]), 32'd0);
            chk("rst_err", 32'(er[g]), 32'd0);
            chk("rst_waddr", wa[g], 32'd0);
            chk("rst_raddr", ra[g], 32'd0);
            chk("rst_wdata", wd[g], 32'd0);
            chk("rst_rdata0", rd[g][0], 32'd0);
            chk("rst_rdata1", rd[g][1], 32'd0);
        end

        // Single read from req0
        cn[0] = 1; cn[1] = 0;
        set_cmd(0, 0, 1'b0, 32'h10, 32'h0);
        push_b(0, 1'b0, 32'h10, 32'h0);
        push_c(0, 0, 32'hDEAD_BEEF, 1'b0);
        run(0);
        chk("read_xfer_len", 32'(last_tlen[0]), 32'd2);

        // Single write from req1
        cn[0] = 0; cn[1] = 1;
        set_cmd(1, 0, 1'b1, 32'h21, 32'h1234_5678);
        push_b(0, 1'b1, 32'h21, 32'h1234_5678);
        push_c(0, 1, 32'h0, 1'b0);
        run(0);
        chk("write_keeps_raddr", ra[0], 32'h10);
        chk("req0_rdata_held", rd[0][0], 32'hDEAD_BEEF);

        // Round-robin contention: grants alternate req0, req1, req0, req1
        cn[0] = 2; cn[1] = 2;
        set_cmd(0, 0, 1'b0, 32'h40, 32'h0);
        set_cmd(0, 1, 1'b1, 32'h44, 32'hAAAA_5555);
        set_cmd(1, 0, 1'b0, 32'h80, 32'h0);
        set_cmd(1, 1, 1'b1, 32'h84, 32'h0F0F_0F0F);
        push_b(0, 1'b0, 32'h40, 32'h0);
        push_b(0, 1'b0, 32'h80, 32'h0);
        push_b(0, 1'b1, 32'h44, 32'hAAAA_5555);
        push_b(0, 1'b1, 32'h84, 32'h0F0F_0F0F);
        push_c(0, 0, 32'h0040_C0DE, 1'b0);
        push_c(0, 1, 32'h0080_C0DE, 1'b0);
        push_c(0, 0, 32'h0040_C0DE, 1'b0);
        push_c(0, 1, 32'h0080_C0DE, 1'b0);
        run(0);

        // Reset while transfer is high: aborted read gives no done
        stall[0] = 1'b1;
        @(negedge PCLK);
        v[0][0] = 1'b1; w[0][0] = 1'b0; a[0][0] = 32'h50;
        #1;
        cyc = 0;
        while (!rdy[0][0] && cyc < 50) begin @(negedge PCLK); #1; cyc++; end
        chk("abort_accept", 32'(rdy[0][0]), 32'd1);
        push_b(0, 1'b0, 32'h50, 32'h0);
        @(posedge PCLK);
        #1 v[0][0] = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("abort_transfer_before", 32'(tr[0]), 32'd1);
        #1 PRESET = 1'b1;
        @(posedge PCLK);
        #1 PRESET = 1'b0;
        stall[0] = 1'b0;
        @(negedge PCLK);
        chk("abort_transfer_after", 32'(tr[0]), 32'd0);
        chk("abort_busy_after", 32'(bsy[0]), 32'd0);
        chk("abort_rdata_cleared", rd[0][0], 32'd0);

        // After reset the rr pointer favours req0 on a tie
        cn[0] = 1; cn[1] = 1;
        set_cmd(0, 0, 1'b0, 32'h70, 32'h0);
        set_cmd(1, 0, 1'b1, 32'h60, 32'h1111_2222);
        push_b(0, 1'b0, 32'h70, 32'h0);
        push_b(0, 1'b1, 32'h60, 32'h1111_2222);
        push_c(0, 0, 32'h0070_C0DE, 1'b0);
        push_c(0, 1, 32'h0, 1'b0);
        run(0);

        // Fixed priority instance: req0 wins every tie, req1 only after req0 drops
        cn[0] = 3; cn[1] = 1;
        set_cmd(0, 0, 1'b0, 32'h100, 32'h0);
        set_cmd(0, 1, 1'b0, 32'h104, 32'h0);
        set_cmd(0, 2, 1'b1, 32'h108, 32'h55);
        set_cmd(1, 0, 1'b0, 32'h200, 32'h0);
        push_b(1, 1'b0, 32'h100, 32'h0);
        push_b(1, 1'b0, 32'h104, 32'h0);
        push_b(1, 1'b1, 32'h108, 32'h55);
        push_b(1, 1'b0, 32'h200, 32'h0);
        push_c(1, 0, 32'h0100_C0DE, 1'b0);
        push_c(1, 0, 32'h0104_C0DE, 1'b0);
        push_c(1, 0, 32'h0104_C0DE, 1'b0);
        push_c(1, 1, 32'h0200_C0DE, 1'b0);
        run(1);

`ifdef APB_REQ_TIMEOUT_EN
        // Stalled slave: abort after 16 transfer cycles with err, rdata untouched
        stall[0] = 1'b1;
        cn[0] = 1; cn[1] = 0;
        set_cmd(0, 0, 1'b0, 32'h90, 32'h0);
        push_b(0, 1'b0, 32'h90, 32'h0);
        push_c(0, 0, 32'h0070_C0DE, 1'b1);
        run(0);
        chk("timeout_xfer_len", 32'(last_tlen[0]), 32'd16);
        stall[0] = 1'b0;
        set_cmd(0, 0, 1'b0, 32'h94, 32'h0);
        push_b(0, 1'b0, 32'h94, 32'h0);
        push_c(0, 0, 32'h0094_C0DE, 1'b0);
        run(0);
`endif

        repeat (3) @(negedge PCLK);
        for (int g = 0; g < 2; g++) begin
            chk("done_queue_empty", 32'(cq[g].size()), 32'd0);
            chk("bridge_queue_empty", 32'(bq[g].size()), 32'd0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
